regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, 32, data width of register values.
REQ-002 SHALL have parameter AW, 5, register address width (2^AW registers).
REQ-003 SHALL have parameter STARVE_MAX, 3, consecutive ALU losses before a forced ALU grant; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports alu_valid input 1, alu_rd input AW, alu_wd input DW: ALU writeback request.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-008 SHALL have ports mem_valid input 1, mem_rd input AW, mem_wd input DW: load-unit writeback request.
REQ-009 SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-010 SHALL have ports rf_we output 1, rf_a3 output AW, rf_wd output DW: registered drive of the register-file write port.
REQ-011 SHALL have ports q_a1 input AW, q_a2 input AW: read addresses being decoded this cycle.
REQ-012 SHALL have ports q_hit1 output 1, q_hit2 output 1: a pending, not-yet-committed write targets q_a1 / q_a2.

Function
REQ-013 SHALL accept at most one request per cycle; a transfer occurs when valid and ready are both 1 at a rising clk edge.
REQ-014 SHALL compute alu_ready and mem_ready combinationally from valids and starvation state; ready never asserts without its own valid.
REQ-015 SHALL grant mem over alu when both are valid, unless the starvation count equals STARVE_MAX, in which case alu is granted.
REQ-016 SHALL grant the sole valid requester when only one is valid.
REQ-017 SHALL increment the starvation count when alu_valid=1 and mem is granted, and clear it to 0 on any alu grant or when alu_valid=0; the count saturates at STARVE_MAX.
REQ-018 SHALL register the granted rd/wd into rf_a3/rf_wd and set rf_we=1 on the edge that completes the transfer (one-cycle latency to the write port).
REQ-019 SHALL set rf_we=0 on any edge without a transfer; rf_a3/rf_wd then hold their last values.
REQ-020 SHALL accept a request with rd=0 normally (ready asserted, starvation updated) but drive rf_we=0 for it.
REQ-021 SHALL assert q_hit1 when rf_we=1, rf_a3==q_a1 and q_a1!=0; likewise q_hit2 for q_a2; purely combinational from registered state.
REQ-022 SHALL leave ready/valid behaviour unaffected when both requesters target the same rd; later-committed value wins by ordering.
REQ-023 SHALL never drop a request: an un-granted valid stays pending until its ready, requester holds rd/wd stable.

Reset
REQ-024 SHALL on rst=1, asynchronously force rf_we=0, rf_a3=0, rf_wd=0, starvation count=0.
REQ-025 SHALL hold alu_ready=0, mem_ready=0, q_hit1=0, q_hit2=0 while rst=1.
REQ-026 SHALL discard any write registered but not committed when rst asserts mid-operation; first grant possible on the first edge after rst deasserts.

Structure
REQ-027 SHALL take DW/AW defaults and the grant encoding (NONE, ALU, MEM) from shared package rf_pkg.
REQ-028 SHALL be a single module; the starvation counter and priority logic stay inline, no sub-module.

Verification
REQ-029 Reset: assert rst mid-cycle with rf_we=1 -> rf_we, rf_a3, rf_wd go 0 immediately, readies 0.
REQ-030 Single: alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF, then rf_we=0.
REQ-031 Contention: both valid for 8 cycles, STARVE_MAX=3 -> grant order MEM,MEM,MEM,ALU,MEM,MEM,MEM,ALU.
REQ-032 x0 write: mem_valid=1, mem_rd=0, mem_wd=0x1234 -> mem_ready=1, next cycle rf_we=0.
REQ-033 Hazard: rf_we=1 with rf_a3=7, q_a1=7, q_a2=0 -> q_hit1=1, q_hit2=0; q_a1=0 with rf_a3=0 -> q_hit1=0.
REQ-034 Back-to-back: alu_valid held 4 cycles, rd=1..4 -> four consecutive rf_we=1 cycles with rf_a3=1,2,3,4.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
package rf_pkg;

  localparam int unsigned RF_DW = 32;
  localparam int unsigned RF_AW = 5;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file.
// The load unit has priority over the ALU. A saturating starvation counter
// forces an ALU grant after STARVE_MAX consecutive losses. The write port is
// registered, and hazard flags report a registered write that has not yet
// committed.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DW         = RF_DW,
  parameter int unsigned AW         = RF_AW,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_wd,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_wd,
  output logic          mem_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] q_a1,
  input  logic [AW-1:0] q_a2,
  output logic          q_hit1,
  output logic          q_hit2
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]    starve;
  grant_e        grant;
  logic [AW-1:0] gnt_rd;
  logic [DW-1:0] gnt_wd;

  // Pick the winner: mem first unless the ALU has lost STARVE_MAX times in a row.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        grant = (starve == STARVE_LIM) ? GNT_ALU : GNT_MEM;
      end else if (alu_valid) begin
        grant = GNT_ALU;
      end else if (mem_valid) begin
        grant = GNT_MEM;
      end
    end
  end

  assign alu_ready = (grant == GNT_ALU);
  assign mem_ready = (grant == GNT_MEM);

  // Mux the granted request onto the write-port inputs.
  always_comb begin
    gnt_rd = alu_rd;
    gnt_wd = alu_wd;
    if (grant == GNT_MEM) begin
      gnt_rd = mem_rd;
      gnt_wd = mem_wd;
    end
  end

  // Starvation counter: counts ALU losses, cleared on an ALU grant or when the ALU is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (alu_valid && (grant == GNT_MEM)) begin
      if (starve != STARVE_LIM) begin
        starve <= starve + 4'd1;
      end
    end else begin
      starve <= '0;
    end
  end

  // Registered write port. Writes to x0 are accepted but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else if (grant != GNT_NONE) begin
      rf_we <= (gnt_rd != '0);
      rf_a3 <= gnt_rd;
      rf_wd <= gnt_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign q_hit1 = !rst && rf_we && (rf_a3 == q_a1) && (q_a1 != '0);
  assign q_hit2 = !rst && rf_we && (rf_a3 == q_a2) && (q_a2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_rd, mem_rd, q_a1, q_a2;
  logic [DW-1:0] alu_wd, mem_wd;
  logic          alu_ready, mem_ready, rf_we, q_hit1, q_hit2;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] cont_order;  // 1 = ALU grant, 0 = MEM grant
    logic [3:0] part_order;
    cont_order = 8'b1000_1000;  // MEM,MEM,MEM,ALU,MEM,MEM,MEM,ALU (LSB first)
    part_order = 4'b1000;       // MEM,MEM,MEM,ALU

    rst = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; alu_wd = '0; mem_rd = '0; mem_wd = '0;
    q_a1 = '0; q_a2 = '0;

    // Reset state, with requests present: readies must stay low
    @(negedge clk);
    alu_valid = 1'b1; mem_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_a3", 32'(rf_a3), 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Single ALU write
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", 32'(alu_ready), 32'd1);
    chk("single_mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_a3", 32'(rf_a3), 32'd5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    chk("idle_alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clk); #1;
    chk("single_we_drop", 32'(rf_we), 32'd0);
    chk("single_a3_hold", 32'(rf_a3), 32'd5);
    chk("single_wd_hold", rf_wd, 32'hDEADBEEF);

    // Hazard detection against a pending write to r7
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h0000_0077;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    q_a1 = 5'd7; q_a2 = 5'd0;
    #1;
    chk("haz_hit1", 32'(q_hit1), 32'd1);
    chk("haz_hit2_x0", 32'(q_hit2), 32'd0);
    q_a2 = 5'd7; q_a1 = 5'd6;
    #1;
    chk("haz_hit2", 32'(q_hit2), 32'd1);
    chk("haz_hit1_miss", 32'(q_hit1), 32'd0);
    @(posedge clk); #1;
    chk("haz_after_commit", 32'(q_hit2), 32'd0);

    // Write to x0 from the load unit: accepted, never enabled
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_wd = 32'h0000_1234;
    #1;
    chk("x0_mem_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    chk("x0_we", 32'(rf_we), 32'd0);
    q_a1 = 5'd0;
    #1;
    chk("x0_hit1", 32'(q_hit1), 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;

    // Contention for 8 cycles with STARVE_MAX=3
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wd = 32'hAAAA_0010;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_wd = 32'hBBBB_0020;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("cont%0d_alu_ready", i), 32'(alu_ready), 32'(cont_order[i]));
      chk($sformatf("cont%0d_mem_ready", i), 32'(mem_ready), 32'(!cont_order[i]));
      @(posedge clk); #1;
      chk($sformatf("cont%0d_a3", i), 32'(rf_a3), cont_order[i] ? 32'd10 : 32'd20);
      @(negedge clk);
    end

    // Idle ALU clears the starvation count
    alu_valid = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("part%0d_mem_ready", i), 32'(mem_ready), 32'd1);
      @(negedge clk);
    end
    alu_valid = 1'b0;
    #1;
    chk("sole_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("restart%0d_alu_ready", i), 32'(alu_ready), 32'(part_order[i]));
      @(negedge clk);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Back-to-back ALU writes to r1..r4
    @(negedge clk);
    alu_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_rd = 5'(i); alu_wd = 32'(100 + i);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_we", i), 32'(rf_we), 32'd1);
      chk($sformatf("b2b%0d_a3", i), 32'(rf_a3), 32'(i));
      chk($sformatf("b2b%0d_wd", i), rf_wd, 32'(100 + i));
      @(negedge clk);
    end
    alu_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_we_drop", 32'(rf_we), 32'd0);

    // Reset asserted mid-cycle while a write is pending
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'hCAFE_0009;
    q_a1 = 5'd9;
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_a3", 32'(rf_a3), 32'd0);
    chk("mid_rst_wd", rf_wd, 32'd0);
    chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("mid_rst_hit1", 32'(q_hit1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    alu_rd = 5'd3; alu_wd = 32'h0000_0333;
    #1;
    chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    chk("post_rst_we", 32'(rf_we), 32'd1);
    chk("post_rst_a3", 32'(rf_a3), 32'd3);
    alu_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
